// File: rtl/aes_pkg.sv
// Shared AES constants for the column-serial SubBytes/ShiftRows stage.
// Holds the byte S-box tables, the ShiftRows index helpers and the FSM encoding.
package aes_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned N_ROWS = 4;
    localparam int unsigned N_COLS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Source column feeding row r of output column c: ShiftRows rotates row r
    // left by r, so forward reads c+r and the inverse reads c-r (mod 4).
    function automatic logic [1:0] src_col(input logic [1:0] c, input logic [1:0] r, input logic inv);
        return inv ? (c - r) : (c + r);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box, forward or inverse selected by dec.
// A constant-zero dec lets synthesis drop the inverse table entirely.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in,
    input  logic       dec,
    output logic [7:0] out
);

    assign out = dec ? INV_SBOX[in] : SBOX[in];

endmodule

// File: rtl/aes_subshift_seq.sv
// Column-serial SubBytes+ShiftRows (or inverse) stage feeding the mix column unit.
// Holds one 128-bit state and emits four transformed columns, one per handshake.
module aes_subshift_seq
    import aes_pkg::*;
#(
    parameter bit DEC_EN = 1'b1
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         dec,
    output logic         col_valid,
    input  logic         col_ready,
    output logic [31:0]  col_out,
    output logic [1:0]   col_idx,
    output logic         col_last
);

    fsm_e         fsm_q;
    logic [127:0] state_q;
    logic         dec_q;
    logic [1:0]   cnt_q;

    logic         dec_eff;
    logic         accept;

    assign dec_eff   = DEC_EN & dec_q;
    assign col_valid = (fsm_q == BUSY);
    // Last-column handshake doubles as the accept window for the next block.
    assign in_ready  = (fsm_q == IDLE) | ((cnt_q == 2'd3) & col_ready);
    assign accept    = in_valid & in_ready;
    assign col_idx   = cnt_q;
    assign col_last  = (cnt_q == 2'd3);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            dec_q   <= 1'b0;
            cnt_q   <= 2'd0;
        end else if (accept) begin
            fsm_q   <= BUSY;
            state_q <= state_in;
            dec_q   <= dec;
            cnt_q   <= 2'd0;
        end else if ((fsm_q == BUSY) && col_ready) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                fsm_q <= IDLE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_ROWS; gi++) begin : g_row
            logic [1:0] src;
            logic [7:0] sel;

            assign src = src_col(cnt_q, 2'(gi), dec_eff);
            assign sel = state_q[{src, 2'(gi), 3'b000} +: BYTE_W];

            aes_sbox u_sbox (
                .in  (sel),
                .dec (dec_eff),
                .out (col_out[BYTE_W*gi +: BYTE_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_aes_subshift_seq.sv
// Scoreboard bench for aes_subshift_seq: driver pushes expected columns at accept,
// monitor pops and compares on every column handshake.
module tb_aes_subshift_seq;

    logic         g_clk = 1'b0;
    logic         g_resetn;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         dec;
    logic         col_valid;
    logic         col_ready;
    logic [31:0]  col_out;
    logic [1:0]   col_idx;
    logic         col_last;

    logic         nd_in_valid;
    logic         nd_in_ready;
    logic [127:0] nd_state_in;
    logic         nd_dec;
    logic         nd_col_valid;
    logic         nd_col_ready;
    logic [31:0]  nd_col_out;
    logic [1:0]   nd_col_idx;
    logic         nd_col_last;

    always #5 g_clk = ~g_clk;

    aes_subshift_seq #(.DEC_EN(1'b1)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in), .dec(dec),
        .col_valid(col_valid), .col_ready(col_ready), .col_out(col_out),
        .col_idx(col_idx), .col_last(col_last)
    );

    aes_subshift_seq #(.DEC_EN(1'b0)) dut_nd (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .in_valid(nd_in_valid), .in_ready(nd_in_ready), .state_in(nd_state_in), .dec(nd_dec),
        .col_valid(nd_col_valid), .col_ready(nd_col_ready), .col_out(nd_col_out),
        .col_idx(nd_col_idx), .col_last(nd_col_last)
    );

    localparam logic [127:0] FWD_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
    localparam logic [127:0] FWD_EXP = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;
    localparam logic [127:0] INV_IN  = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;
    localparam logic [127:0] INV_EXP = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
    localparam logic [127:0] ZERO_F  = {4{32'h63636363}};
    localparam logic [127:0] ZERO_I  = {4{32'h52525252}};

    typedef struct packed {
        logic [31:0] col;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    logic lat_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: scoreboard pops, first-column latency and backpressure stability.
    initial begin : monitor
        exp_t        e;
        logic        hold_valid;
        logic [34:0] hold;
        hold_valid = 1'b0;
        forever begin
            @(negedge g_clk);
            if (!g_resetn) begin
                hold_valid = 1'b0;
            end else begin
                if (lat_pending) begin
                    check("first_col_valid", 64'(col_valid), 64'd1);
                    check("first_col_idx", 64'(col_idx), 64'd0);
                    lat_pending = 1'b0;
                end
                if (hold_valid) begin
                    check("bp_stable", 64'({col_valid, col_out, col_idx, col_last}), 64'({1'b1, hold}));
                end
                if (col_valid && col_ready) begin
                    hold_valid = 1'b0;
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_col actual=%h required=none", col_out);
                    end else begin
                        e = sb_q.pop_front();
                        check("col_out", 64'(col_out), 64'(e.col));
                        check("col_idx", 64'(col_idx), 64'(e.idx));
                        check("col_last", 64'(col_last), 64'(e.last));
                        check("in_ready_beat", 64'(in_ready), 64'(e.idx == 2'd3));
                        $display("beat t=%0t col_idx=%0d col_out=%h last=%0b", $time, col_idx, col_out, col_last);
                    end
                end else if (col_valid) begin
                    hold = {col_out, col_idx, col_last};
                    hold_valid = 1'b1;
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                end else begin
                    hold_valid = 1'b0;
                end
            end
        end
    end

    task automatic send_block(input logic [127:0] st, input logic d, input logic [127:0] cols);
        int   n;
        exp_t e;
        state_in = st;
        dec      = d;
        in_valid = 1'b1;
        n = 0;
        @(negedge g_clk);
        while (!in_ready && n < 50) begin
            @(negedge g_clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        end else begin
            for (int i = 0; i < 4; i++) begin
                e.col  = cols[32*i +: 32];
                e.idx  = 2'(i);
                e.last = (i == 3);
                sb_q.push_back(e);
            end
            $display("accept t=%0t state=%h dec=%0b", $time, st, d);
        end
        @(posedge g_clk);
        if (in_ready) lat_pending = 1'b1;
        #1;
        in_valid = 1'b0;
        dec      = ~d;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge g_clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [6:0] bp_pat;
        int         n;
        g_resetn = 1'b0;
        in_valid = 1'b0;
        state_in = '0;
        dec = 1'b0;
        col_ready = 1'b1;
        nd_in_valid = 1'b0;
        nd_state_in = '0;
        nd_dec = 1'b0;
        nd_col_ready = 1'b1;

        repeat (2) @(negedge g_clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_col_valid", 64'(col_valid), 64'd0);
        check("rst_col_idx", 64'(col_idx), 64'd0);
        check("rst_col_last", 64'(col_last), 64'd0);
        check("rst_col_out", 64'(col_out), 64'h63636363);
        g_resetn = 1'b1;
        idle_cycles(2);

        send_block(FWD_IN, 1'b0, FWD_EXP);
        idle_cycles(6);
        send_block(INV_IN, 1'b1, INV_EXP);
        idle_cycles(6);

        // Backpressure pattern, applied from the first column cycle onward.
        bp_pat = 7'b1101001;
        send_block(FWD_IN, 1'b0, FWD_EXP);
        for (int i = 0; i < 7; i++) begin
            col_ready = bp_pat[i];
            @(posedge g_clk);
            #1;
        end
        col_ready = 1'b1;
        idle_cycles(4);

        send_block(FWD_IN, 1'b0, FWD_EXP);
        send_block(INV_IN, 1'b1, INV_EXP);
        idle_cycles(6);

        // Asynchronous reset in the middle of a block.
        send_block(FWD_IN, 1'b0, FWD_EXP);
        n = 0;
        @(negedge g_clk);
        while (col_idx != 2'd1 && n < 20) begin
            @(negedge g_clk);
            n++;
        end
        check("mid_reached_col1", 64'(col_idx), 64'd1);
        #2;
        g_resetn = 1'b0;
        #1;
        check("mid_rst_col_valid", 64'(col_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        lat_pending = 1'b0;
        repeat (2) @(negedge g_clk);
        #2;
        g_resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge g_clk);
            check("no_stale_col", 64'(col_valid), 64'd0);
        end
        @(posedge g_clk);
        #1;
        send_block('0, 1'b0, ZERO_F);
        idle_cycles(6);
        send_block('0, 1'b1, ZERO_I);
        idle_cycles(6);

        // DEC_EN=0 instance ignores dec=1.
        nd_state_in = FWD_IN;
        nd_dec = 1'b1;
        nd_in_valid = 1'b1;
        @(posedge g_clk);
        #1;
        nd_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge g_clk);
            check("nd_col_valid", 64'(nd_col_valid), 64'd1);
            check("nd_col_idx", 64'(nd_col_idx), 64'(i));
            check("nd_col_out", 64'(nd_col_out), 64'(FWD_EXP[32*i +: 32]));
            $display("nd_beat t=%0t col_idx=%0d col_out=%h", $time, nd_col_idx, nd_col_out);
        end
        idle_cycles(2);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
